pl_alu_seq: RTL

//   Parametrised, handshaked successor to the EX-stage ALU: WIDTH-bit datapath with a registered result.

---
 rtl/pl_alu_seq.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pl_alu_seq.sv
// pl_alu_seq: handshaked EX-stage ALU with a registered result.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/NOT/CMP, and illegal opcodes) produce a
// result one cycle after accept. SHL/SHR shift one bit per cycle (n cycles, with
// n = 0 or 1 finishing in one). MUL is an unsigned shift-add that takes WIDTH cycles.
// The accept edge always performs the first shift/multiply step.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake (in_ready high only in IDLE)
//   opcode, op1, op2    operation and operands (op2[SHW-1:0] is the shift amount)
//   carry_in            carry into ADD
//   out_valid/out_ready result handshake; the result is held until consumed
//   dout, dout_hi       result (MUL: low/high halves of the product)
//   cout                ADD/SUB/CMP carry out, SHL/SHR last bit shifted out
//   comp_gt/lt/eq       CMP unsigned relation flags
//   op_err              illegal opcode
module pl_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_hi,
  output logic             cout,
  output logic             comp_gt,
  output logic             comp_lt,
  output logic             comp_eq,
  output logic             op_err
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       opc_q, opc_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] dout_hi_q, dout_hi_d;
  logic             cout_q, cout_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             err_q, err_d;

  // Single-cycle arithmetic on the live operands
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [SHW-1:0]   sh_amt;

  always_comb begin
    add_sum = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, carry_in};
    sub_sum = {1'b0, op1} + {1'b0, ~op2} + {{WIDTH{1'b0}}, 1'b1};
    sh_amt  = op2[SHW-1:0];
  end

  // One iteration of shift / shift-add multiply. In IDLE it works on the
  // incoming operands (first step on the accept edge), otherwise on the work regs.
  logic [3:0]       step_op;
  logic [WIDTH-1:0] step_lo, step_hi, step_mc;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_res_lo, step_res_hi;
  logic             step_res_co;

  always_comb begin
    if (state_q == S_IDLE) begin
      step_op = opcode;
      step_lo = (opcode == OP_MUL) ? op2 : op1;
      step_hi = '0;
      step_mc = op1;
    end else begin
      step_op = opc_q;
      step_lo = work_lo_q;
      step_hi = work_hi_q;
      step_mc = mcand_q;
    end

    mul_sum = {1'b0, step_hi} + (step_lo[0] ? {1'b0, step_mc} : {(WIDTH + 1){1'b0}});

    case (step_op)
      OP_SHL: begin
        step_res_lo = {step_lo[WIDTH-2:0], 1'b0};
        step_res_hi = '0;
        step_res_co = step_lo[WIDTH-1];
      end
      OP_SHR: begin
        step_res_lo = {1'b0, step_lo[WIDTH-1:1]};
        step_res_hi = '0;
        step_res_co = step_lo[0];
      end
      default: begin
        // Product shifts right through {hi, lo}; multiplier bits leave lo[0]
        step_res_lo = {mul_sum[0], step_lo[WIDTH-1:1]};
        step_res_hi = mul_sum[WIDTH:1];
        step_res_co = 1'b0;
      end
    endcase
  end

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    work_hi_d   = work_hi_q;
    work_lo_d   = work_lo_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    dout_hi_d   = dout_hi_q;
    cout_d      = cout_q;
    gt_d        = gt_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opc_d       = opcode;
          dout_d      = '0;
          dout_hi_d   = '0;
          cout_d      = 1'b0;
          gt_d        = 1'b0;
          lt_d        = 1'b0;
          eq_d        = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
          case (opcode)
            OP_ADD: begin
              dout_d = add_sum[WIDTH-1:0];
              cout_d = add_sum[WIDTH];
            end
            OP_SUB: begin
              dout_d = sub_sum[WIDTH-1:0];
              cout_d = sub_sum[WIDTH];
            end
            OP_AND: dout_d = op1 & op2;
            OP_OR:  dout_d = op1 | op2;
            OP_XOR: dout_d = op1 ^ op2;
            OP_NOT: dout_d = ~op1;
            OP_CMP: begin
              dout_d = sub_sum[WIDTH-1:0];
              cout_d = sub_sum[WIDTH];
              gt_d   = (op1 > op2);
              lt_d   = (op1 < op2);
              eq_d   = (op1 == op2);
            end
            OP_SHL, OP_SHR: begin
              if (sh_amt == '0) begin
                dout_d = op1;
              end else if (sh_amt == SHW'(1)) begin
                dout_d = step_res_lo;
                cout_d = step_res_co;
              end else begin
                out_valid_d = 1'b0;
                state_d     = S_BUSY;
                work_lo_d   = step_res_lo;
                cnt_d       = CNTW'(sh_amt) - CNTW'(1);
              end
            end
            OP_MUL: begin
              out_valid_d = 1'b0;
              state_d     = S_BUSY;
              work_hi_d   = step_res_hi;
              work_lo_d   = step_res_lo;
              mcand_d     = op1;
              cnt_d       = CNTW'(WIDTH - 1);
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      S_BUSY: begin
        // cnt_q holds the steps still to run, including this one
        work_hi_d = step_res_hi;
        work_lo_d = step_res_lo;
        cnt_d     = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          dout_d      = step_res_lo;
          dout_hi_d   = step_res_hi;
          cout_d      = step_res_co;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          dout_d      = '0;
          dout_hi_d   = '0;
          cout_d      = 1'b0;
          gt_d        = 1'b0;
          lt_d        = 1'b0;
          eq_d        = 1'b0;
          err_d       = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      opc_q       <= '0;
      work_hi_q   <= '0;
      work_lo_q   <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      dout_hi_q   <= '0;
      cout_q      <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      work_hi_q   <= work_hi_d;
      work_lo_q   <= work_lo_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      dout_hi_q   <= dout_hi_d;
      cout_q      <= cout_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign dout_hi   = dout_hi_q;
  assign cout      = cout_q;
  assign comp_gt   = gt_q;
  assign comp_lt   = lt_q;
  assign comp_eq   = eq_q;
  assign op_err    = err_q;

endmodule
